// File: rtl/idx_mask_decoder.sv
// Rebuilds a bit mask from a stream of encoded indices and hands the finished mask with its population count downstream.
// Optional ascending-order checking is enabled by defining IDX_MASK_DECODER_ORDER_CHECK_EN.
module idx_mask_decoder #(
   parameter int IDX_W = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [IDX_W-1:0]      in_idx,
   input  logic                  in_v,
   input  logic                  in_last,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [2**IDX_W-1:0]   out_mask,
   output logic [IDX_W:0]        out_cnt,
   output logic                  out_dup,
   output logic                  out_err,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);

   typedef enum logic {ACCUM, HOLD} state_t;

   state_t state;
   logic   beat_fire;
   logic   frame_done;

   assign in_ready   = (state == ACCUM);
   assign out_valid  = (state == HOLD);
   assign beat_fire  = in_valid && (state == ACCUM);
   assign frame_done = (state == HOLD) && out_ready;

   // A duplicate leaves mask and count alone, so the count can never exceed the mask width.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ACCUM;
         out_mask <= '0;
         out_cnt  <= '0;
         out_dup  <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (beat_fire) begin
                  if (in_v) begin
                     if (out_mask[in_idx]) begin
                        out_dup <= 1'b1;
                     end else begin
                        out_mask[in_idx] <= 1'b1;
                        out_cnt          <= out_cnt + CNT_ONE;
                     end
                  end
                  if (in_last) begin
                     state <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (frame_done) begin
                  state    <= ACCUM;
                  out_mask <= '0;
                  out_cnt  <= '0;
                  out_dup  <= 1'b0;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

`ifdef IDX_MASK_DECODER_ORDER_CHECK_EN
   logic [IDX_W-1:0] prev_idx;
   logic             have_prev;
   logic             err_q;

   // Encoders emit low-to-high, so any valid index not above the last one (repeats included) is an ordering fault.
   always_ff @(posedge clk) begin
      if (rst || frame_done) begin
         prev_idx  <= '0;
         have_prev <= 1'b0;
         err_q     <= 1'b0;
      end else if (beat_fire && in_v) begin
         if (have_prev && (in_idx <= prev_idx)) begin
            err_q <= 1'b1;
         end
         prev_idx  <= in_idx;
         have_prev <= 1'b1;
      end
   end

   assign out_err = err_q;
`else
   assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_idx_mask_decoder.sv
// Directed, table-driven bench for idx_mask_decoder; every row is one clock with outputs checked just after the edge.
module tb_idx_mask_decoder;

`ifdef IDX_MASK_DECODER_ORDER_CHECK_EN
   localparam logic ORD = 1'b1;
`else
   localparam logic ORD = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic [2:0] in_idx;
   logic       in_v;
   logic       in_last;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_mask;
   logic [3:0] out_cnt;
   logic       out_dup;
   logic       out_err;
   logic       out_valid;
   logic       out_ready;

   int n_cmp;
   int n_fail;

   typedef struct {
      logic [2:0] idx;
      logic       v;
      logic       last;
      logic       valid;
      logic       ordy;
      logic       exp_rdy;
      logic       exp_ov;
      logic [7:0] exp_mask;
      logic [3:0] exp_cnt;
      logic       exp_dup;
      logic       exp_err;
   } vec_t;

   vec_t vecs[$];

   idx_mask_decoder #(.IDX_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_idx    (in_idx),
      .in_v      (in_v),
      .in_last   (in_last),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_mask  (out_mask),
      .out_cnt   (out_cnt),
      .out_dup   (out_dup),
      .out_err   (out_err),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic [2:0] idx, logic v, logic last, logic valid, logic ordy,
                               logic exp_rdy, logic exp_ov, logic [7:0] exp_mask,
                               logic [3:0] exp_cnt, logic exp_dup, logic exp_err);
      vec_t r;
      r.idx = idx; r.v = v; r.last = last; r.valid = valid; r.ordy = ordy;
      r.exp_rdy = exp_rdy; r.exp_ov = exp_ov; r.exp_mask = exp_mask;
      r.exp_cnt = exp_cnt; r.exp_dup = exp_dup; r.exp_err = exp_err;
      return r;
   endfunction

   task automatic cmp(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drives one cycle of inputs and returns 1 time unit after the rising edge.
   task automatic applyStimulus(input logic [2:0] idx, input logic v, input logic last,
                                input logic valid, input logic ordy);
      in_idx    = idx;
      in_v      = v;
      in_last   = last;
      in_valid  = valid;
      out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic exp_rdy, input logic exp_ov,
                              input logic [7:0] exp_mask, input logic [3:0] exp_cnt,
                              input logic exp_dup, input logic exp_err);
      cmp({tag, ".in_ready"},  int'(in_ready),  int'(exp_rdy));
      cmp({tag, ".out_valid"}, int'(out_valid), int'(exp_ov));
      cmp({tag, ".out_mask"},  int'(out_mask),  int'(exp_mask));
      cmp({tag, ".out_cnt"},   int'(out_cnt),   int'(exp_cnt));
      cmp({tag, ".out_dup"},   int'(out_dup),   int'(exp_dup));
      cmp({tag, ".out_err"},   int'(out_err),   int'(exp_err));
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;

      // Frame 1,4,6 with an idle gap; empty frame; frame 3,3,5; frame 5,(empty 7),2.
      vecs.push_back(mk(3'd1, 1, 0, 1, 1,  1, 0, 8'h02, 4'd1, 0, 0));
      vecs.push_back(mk(3'd0, 0, 0, 0, 1,  1, 0, 8'h02, 4'd1, 0, 0));
      vecs.push_back(mk(3'd4, 1, 0, 1, 1,  1, 0, 8'h12, 4'd2, 0, 0));
      vecs.push_back(mk(3'd6, 1, 1, 1, 1,  0, 1, 8'h52, 4'd3, 0, 0));
      vecs.push_back(mk(3'd0, 0, 0, 0, 1,  1, 0, 8'h00, 4'd0, 0, 0));
      vecs.push_back(mk(3'd0, 0, 1, 1, 1,  0, 1, 8'h00, 4'd0, 0, 0));
      vecs.push_back(mk(3'd0, 0, 0, 0, 1,  1, 0, 8'h00, 4'd0, 0, 0));
      vecs.push_back(mk(3'd3, 1, 0, 1, 1,  1, 0, 8'h08, 4'd1, 0, 0));
      vecs.push_back(mk(3'd3, 1, 0, 1, 1,  1, 0, 8'h08, 4'd1, 1, ORD));
      vecs.push_back(mk(3'd5, 1, 1, 1, 1,  0, 1, 8'h28, 4'd2, 1, ORD));
      vecs.push_back(mk(3'd0, 0, 0, 0, 1,  1, 0, 8'h00, 4'd0, 0, 0));
      vecs.push_back(mk(3'd5, 1, 0, 1, 1,  1, 0, 8'h20, 4'd1, 0, 0));
      vecs.push_back(mk(3'd7, 0, 0, 1, 1,  1, 0, 8'h20, 4'd1, 0, 0));
      vecs.push_back(mk(3'd2, 1, 1, 1, 1,  0, 1, 8'h24, 4'd2, 0, ORD));
      vecs.push_back(mk(3'd0, 0, 0, 0, 1,  1, 0, 8'h00, 4'd0, 0, 0));

      rst = 1'b1;
      applyStimulus(3'd0, 0, 0, 0, 0);
      applyStimulus(3'd0, 0, 0, 0, 0);
      checkOutput("reset", 1, 0, 8'h00, 4'd0, 0, 0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].idx, vecs[i].v, vecs[i].last, vecs[i].valid, vecs[i].ordy);
         checkOutput($sformatf("vec%0d", i), vecs[i].exp_rdy, vecs[i].exp_ov,
                     vecs[i].exp_mask, vecs[i].exp_cnt, vecs[i].exp_dup, vecs[i].exp_err);
      end

      // Full ascending frame, then a held result that must ignore input pulses.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(3'(i), 1, (i == 7), 1, 0);
      end
      checkOutput("full", 0, 1, 8'hFF, 4'd8, 0, 0);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(3'd0, 1, 1, (k % 2 == 0), 0);
         checkOutput($sformatf("hold%0d", k), 0, 1, 8'hFF, 4'd8, 0, 0);
      end
      applyStimulus(3'd0, 0, 0, 0, 1);
      checkOutput("full_accept", 1, 0, 8'h00, 4'd0, 0, 0);

      // Reset mid-frame must drop partial bits and the previous-index history.
      applyStimulus(3'd2, 1, 0, 1, 1);
      applyStimulus(3'd7, 1, 0, 1, 1);
      checkOutput("partial", 1, 0, 8'h84, 4'd2, 0, 0);
      rst = 1'b1;
      applyStimulus(3'd0, 0, 0, 0, 1);
      checkOutput("midrst", 1, 0, 8'h00, 4'd0, 0, 0);
      rst = 1'b0;
      applyStimulus(3'd0, 1, 1, 1, 0);
      checkOutput("after_rst", 0, 1, 8'h01, 4'd1, 0, 0);
      applyStimulus(3'd0, 0, 0, 0, 1);
      checkOutput("after_rst_acc", 1, 0, 8'h00, 4'd0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/idx_mask_decoder.md
Name: idx_mask_decoder

Overview:
- Sequential decoder for index streams produced by the team's priority encoders.
- Accepts a stream of encoded indices (index plus valid-bit pair) over a valid/ready handshake.
- Reconstructs the bit mask one set bit per beat and presents the finished mask, with a population count, on an output valid/ready handshake.
- Sits downstream of an encoder or serial link; returns index frames to mask form.

Parameters:
- IDX_W, 3, index width; mask width is 2**IDX_W (8 at default).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_idx  input  IDX_W  encoded bit index.
- in_v  input  1  index-valid flag (encoder "v"); 0 means the beat carries no bit.
- in_last  input  1  final beat of the current frame.
- in_valid  input  1  input beat present.
- in_ready  output  1  decoder can accept a beat.
- out_mask  output  2**IDX_W  reconstructed mask.
- out_cnt  output  IDX_W+1  number of distinct bits set in out_mask.
- out_dup  output  1  at least one index in the frame repeated an already-set bit.
- out_err  output  1  ordering error (see Optional Feature).
- out_valid  output  1  frame result valid.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge.
- Reset state:
  - state = ACCUM.
  - in_ready = 1, out_valid = 0.
  - out_mask = 0, out_cnt = 0, out_dup = 0, out_err = 0.
  - Internal previous-index tracking cleared.
  - Reset mid-frame or mid-hold discards all partial data. No output is produced for that frame.
- States: ACCUM, HOLD. All outputs are registered. in_ready = (state == ACCUM).
- ACCUM, beat accepted (in_valid & in_ready):
  - in_v = 1, bit in_idx clear: set mask bit in_idx, cnt += 1.
  - in_v = 1, bit already set: mask and cnt unchanged, dup <= 1.
  - in_v = 0: mask, cnt and dup unchanged (empty beat).
  - in_last = 1: go to HOLD. out_valid rises the cycle after the accepting edge. out_mask, out_cnt and out_dup reflect all beats including the last.
- ACCUM, no beat: hold all state.
- HOLD:
  - in_ready = 0; in_valid is ignored.
  - out_valid = 1, and outputs are stable until accepted.
  - When out_valid & out_ready: mask, cnt, dup and err are cleared at that edge, state returns to ACCUM, and in_ready = 1 next cycle.
- Latency: last beat accepted at edge N means out_valid = 1 after edge N. Minimum frame period is 2 cycles (last beat, then a 1-cycle hold with out_ready held high).
- Width and boundary rules:
  - out_cnt saturates naturally at 2**IDX_W, because duplicates never increment it.
  - Empty frame (single beat, in_v = 0, in_last = 1) yields mask 0 and cnt 0.
  - Full frame (all 2**IDX_W indices) yields an all-ones mask and cnt = 2**IDX_W (8 at default, which fits IDX_W+1 bits).
- Simultaneous events:
  - rst wins over any handshake.
  - A beat and a result acceptance cannot coincide, because in_ready is low in HOLD.
- out_mask, out_cnt and out_dup are visible as running values during ACCUM. Consumers use them only when out_valid = 1.

Optional Feature:
- Macro: IDX_MASK_DECODER_ORDER_CHECK_EN.
- Defined:
  - Each accepted beat with in_v = 1 must have in_idx strictly greater than the previous in_v = 1 index of the same frame. This matches encoder low-to-high priority emission.
  - A violation sets out_err, sticky until the frame is accepted or rst.
  - The first valid index in a frame is always accepted.
  - A duplicate index also violates ordering, so it sets out_err as well as out_dup.
- Not defined: out_err is tied to 0 and no previous-index register is instantiated.

Test Plan:
- Reset, then frame idx 1, 4, 6 (in_v = 1, last on 6), out_ready = 1 -> out_valid exactly 1 cycle after the 6 beat; out_mask = 8'b0101_0010, out_cnt = 3, out_dup = 0, out_err = 0. in_ready low for exactly that cycle.
- Single beat in_v = 0, in_last = 1 -> out_mask = 0, out_cnt = 0, out_valid = 1 the next cycle.
- Frame 0..7 ascending, out_ready = 0 for 5 cycles -> out_mask = 8'hFF and out_cnt = 8 held stable. in_ready = 0 throughout, and in_valid pulses during HOLD are ignored. Release out_ready -> accept, then in_ready = 1 next cycle.
- Frame idx 3, 3, 5 -> out_mask = 8'b0010_1000, out_cnt = 2, out_dup = 1. out_err = 1 only with IDX_MASK_DECODER_ORDER_CHECK_EN defined.
- With the macro defined, frame 5, 2 -> out_err = 1, out_mask = 8'b0010_0100, out_cnt = 2. Without the macro, out_err = 0.
- Assert rst after beats 2 and 7, then send frame idx 0 (last) -> out_mask = 8'b0000_0001, out_cnt = 1. No stale bits from the aborted frame appear.
